// File: rtl/seq_pkg.sv
// Shared definitions for the count sequencer: FSM state encoding and default width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_pkg;

  // Counter and limit width used when the instantiating module does not override it.
  localparam int DEFAULT_WIDTH = 4;

  // Encoding is visible on the state output, so the values are fixed.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  // A run is in progress while counting or frozen mid-run.
  function automatic logic is_busy(input state_t st);
    return (st == RUN) || (st == HOLD);
  endfunction

endpackage

// File: rtl/count_sequencer_if.sv
// Control/status bundle for the count sequencer.
// Latency: n/a (wires only).
// Backpressure: none; controls are level-sampled every clock edge.
//
// Ports (seen from the sequencer, modport slave):
//   start, stop, hold, periodic : control levels in
//   limit                       : terminal count in (sampled with start)
//   count, tick, busy, state    : status out
interface count_sequencer_if
  import seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic             stop;
  logic             hold;
  logic             periodic;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             busy;
  state_t           state;

  // Controller side: drives the controls, observes the status.
  modport master (
    output start, stop, hold, periodic, limit,
    input  count, tick, busy, state
  );

  // Sequencer side.
  modport slave (
    input  start, stop, hold, periodic, limit,
    output count, tick, busy, state
  );

endinterface

// File: rtl/count_core.sv
// WIDTH-bit counter register with increment enable and synchronous clear.
// Latency: q reflects clr/en one cycle after the edge that samples them.
// Backpressure: none; when neither clr nor en is asserted the value is held.
//
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clr      : clear to zero on the next edge (wins over en)
//   en       : increment by one on the next edge
//   q        : current count
module count_core #(
  parameter int WIDTH = seq_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Run-length sequencer: counts 0..limit, pulses tick on terminal count, one-shot or auto-reload.
// Latency: all outputs registered except busy (decoded from state); tick follows the terminal edge by one cycle.
// Backpressure: hold freezes the count; stop aborts to idle; start is ignored while a run is active.
//
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : control (start/stop/hold/periodic/limit) and status (count/tick/busy/state)
module count_sequencer
  import seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                clk,
  input logic                rst,
  count_sequencer_if.slave   bus
);

  state_t           state_q;
  logic [WIDTH-1:0] limit_q;
  logic             periodic_q;
  logic             tick_q;
  logic [WIDTH-1:0] count;
  logic             term;
  logic             cnt_clr;
  logic             cnt_en;

  // Terminal compare against the limit latched at start; never against the live input.
  assign term = (count == limit_q);

  // Counter control. Priority mirrors the FSM: stop, terminal, hold, start.
  // A terminal one-shot leaves both controls low so the count parks at limit_q.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (bus.stop) begin
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: cnt_clr = bus.start;
        RUN: begin
          if (term) begin
            cnt_clr = periodic_q;
          end else if (!bus.hold) begin
            cnt_en = 1'b1;
          end
        end
        // HOLD: frozen; the edge that leaves HOLD does not count either.
        default: ;
      endcase
    end
  end

  count_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .q   (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_q     <= 1'b0;
      limit_q    <= '0;
      periodic_q <= 1'b0;
    end else if (bus.stop) begin
      state_q <= IDLE;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q    <= RUN;
            limit_q    <= bus.limit;
            periodic_q <= bus.periodic;
          end
        end
        RUN: begin
          // Terminal wins over hold so a tick is never swallowed by a freeze.
          if (term) begin
            tick_q <= 1'b1;
            if (!periodic_q) begin
              state_q <= DONE;
            end
          end else if (bus.hold) begin
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (!bus.hold) begin
            state_q <= RUN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.count = count;
  assign bus.tick  = tick_q;
  assign bus.state = state_q;
  assign bus.busy  = is_busy(state_q);

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with hand-computed expected outputs.
// Latency: expectations are taken 1 ns after each rising edge.
// Backpressure: hold/stop exercised directly; no waits on DUT events.
module tb_count_sequencer;

  logic clk;
  logic rst;
  int   nvec;
  int   nmis;

  count_sequencer_if #(.WIDTH(4)) bus ();

  count_sequencer #(
    .WIDTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Compare all four status outputs; busy is expected high only in RUN (1) and HOLD (2).
  task automatic expect_out(input string tag, input int st, input int cnt, input int tk);
    check({tag, ".state"}, 32'(bus.state), 32'(st));
    check({tag, ".count"}, 32'(bus.count), 32'(cnt));
    check({tag, ".tick"},  32'(bus.tick),  32'(tk));
    check({tag, ".busy"},  32'(bus.busy),  32'((st == 1) || (st == 2)));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    nvec         = 0;
    nmis         = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.hold     = 1'b0;
    bus.periodic = 1'b0;
    bus.limit    = 4'd0;

    step;
    expect_out("reset", 0, 0, 0);
    rst = 1'b0;

    // One-shot, limit 3; limit changed to 1 mid-run must not matter.
    bus.limit = 4'd3; bus.periodic = 1'b0; bus.start = 1'b1;
    step;
    expect_out("os_start", 1, 0, 0);
    bus.start = 1'b0; bus.limit = 4'd1;
    for (int k = 1; k <= 3; k++) begin
      step;
      expect_out($sformatf("os_cnt%0d", k), 1, k, 0);
    end
    step;
    expect_out("os_tick", 3, 3, 1);
    step;
    expect_out("os_done", 3, 3, 0);

    // Restart from DONE picks up limit 1; hold on the terminal edge still ticks.
    bus.start = 1'b1;
    step;
    expect_out("r2_start", 1, 0, 0);
    bus.start = 1'b0;
    step;
    expect_out("r2_c1", 1, 1, 0);
    bus.hold = 1'b1;
    step;
    expect_out("r2_term_hold", 3, 1, 1);
    bus.hold = 1'b0;

    // Periodic, limit 2; later changes to limit/periodic ignored.
    bus.limit = 4'd2; bus.periodic = 1'b1; bus.start = 1'b1;
    step;
    expect_out("per_start", 1, 0, 0);
    bus.start = 1'b0; bus.limit = 4'd7; bus.periodic = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step;
      expect_out($sformatf("per%0d", k), 1, k % 3, (k % 3) == 0 ? 1 : 0);
    end
    bus.stop = 1'b1;
    step;
    expect_out("stop_run", 0, 0, 0);
    bus.stop = 1'b0;

    // Hold at count 2 for three cycles, limit 5; start held high once mid-run is ignored.
    bus.limit = 4'd5; bus.start = 1'b1;
    step;
    expect_out("h_start", 1, 0, 0);
    step;
    expect_out("h_ign_start", 1, 1, 0);
    bus.start = 1'b0;
    step;
    expect_out("h_c2", 1, 2, 0);
    bus.hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step;
      expect_out($sformatf("h_hold%0d", k), 2, 2, 0);
    end
    bus.hold = 1'b0;
    step;
    expect_out("h_release", 1, 2, 0);
    for (int k = 3; k <= 5; k++) begin
      step;
      expect_out($sformatf("h_resume%0d", k), 1, k, 0);
    end
    step;
    expect_out("h_tick", 3, 5, 1);

    // stop and hold together at count 4.
    bus.limit = 4'd9; bus.start = 1'b1;
    step;
    expect_out("sh_start", 1, 0, 0);
    bus.start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step;
      expect_out($sformatf("sh_cnt%0d", k), 1, k, 0);
    end
    bus.stop = 1'b1; bus.hold = 1'b1;
    step;
    expect_out("sh_stop", 0, 0, 0);
    bus.stop = 1'b0; bus.hold = 1'b0;
    step;
    expect_out("sh_idle", 0, 0, 0);

    // limit 0 periodic: tick every cycle, count stuck at 0.
    bus.limit = 4'd0; bus.periodic = 1'b1; bus.start = 1'b1;
    step;
    expect_out("z_start", 1, 0, 0);
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step;
      expect_out($sformatf("z_tick%0d", k), 1, 0, 1);
    end
    bus.stop = 1'b1;
    step;
    expect_out("z_stop", 0, 0, 0);
    bus.stop = 1'b0;

    // Reset mid-run, then full-range one-shot to 15.
    bus.limit = 4'd15; bus.periodic = 1'b0; bus.start = 1'b1;
    step;
    expect_out("f_start", 1, 0, 0);
    bus.start = 1'b0;
    step;
    expect_out("f_c1", 1, 1, 0);
    step;
    expect_out("f_c2", 1, 2, 0);
    rst = 1'b1;
    step;
    expect_out("f_rst", 0, 0, 0);
    rst = 1'b0;
    step;
    expect_out("f_idle", 0, 0, 0);
    bus.start = 1'b1;
    step;
    expect_out("f_restart", 1, 0, 0);
    bus.start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step;
      expect_out($sformatf("f_cnt%0d", k), 1, k, 0);
    end
    step;
    expect_out("f_tick", 3, 15, 1);
    step;
    expect_out("f_done", 3, 15, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
